// File: rtl/zxuno_regbus_ctrl_if.sv
// CPU-side and peripheral-side signals of the ZX-UNO register bus sequencer.
// The master modport is the bus environment (CPU and peripherals); the slave modport is the controller.
interface zxuno_regbus_ctrl_if #(
    parameter int NPERIPH = 8
);
    logic [15:0]            a;
    logic                   iorq_n;
    logic                   rd_n;
    logic                   wr_n;
    logic [7:0]             din;
    logic [8*NPERIPH-1:0]   periph_dout;
    logic [NPERIPH-1:0]     periph_oe_n;
    logic [7:0]             zxuno_addr;
    logic                   regaddr_changed;
    logic                   zxuno_regrd;
    logic                   zxuno_regwr;
    logic [7:0]             zxuno_wdata;
    logic [7:0]             dout;
    logic                   oe_n;
    logic                   bus_conflict;

    modport master (
        output a, iorq_n, rd_n, wr_n, din, periph_dout, periph_oe_n,
        input  zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, zxuno_wdata,
               dout, oe_n, bus_conflict
    );

    modport slave (
        input  a, iorq_n, rd_n, wr_n, din, periph_dout, periph_oe_n,
        output zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, zxuno_wdata,
               dout, oe_n, bus_conflict
    );
endinterface

// File: rtl/zxuno_regbus_ctrl.sv
// ZX-UNO register bus sequencer and peripheral read arbiter (lowest index wins).
// Optional sticky multi-driver detection is built when ZXUNO_REGBUS_CONFLICT_EN is defined.
module zxuno_regbus_ctrl #(
    parameter int          NPERIPH   = 8,
    parameter logic [15:0] ADDR_PORT = 16'hFC3B,
    parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
    input  logic            clk,
    input  logic            rst_n,
    zxuno_regbus_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic       access_rd, access_wr, hit_addr, hit_data;
    logic       active, active_reg, start;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic [7:0] dout_reg, dout_next;
    logic       chg_reg, chg_next;
    logic       wr_reg, wr_next;
    logic       regrd_reg, regrd_next;
    logic       oe_n_reg, oe_n_next;
    logic [7:0] arb_data;
    logic [7:0] pdat [NPERIPH];

    assign access_rd = !bus.iorq_n && !bus.rd_n && bus.wr_n;
    assign access_wr = !bus.iorq_n && !bus.wr_n && bus.rd_n;
    assign hit_addr  = (bus.a == ADDR_PORT);
    assign hit_data  = (bus.a == DATA_PORT);
    assign active    = (access_rd || access_wr) && (hit_addr || hit_data);
    assign start     = active && !active_reg;

    for (genvar gi = 0; gi < NPERIPH; gi++) begin : g_unpack
        assign pdat[gi] = bus.periph_dout[8*gi +: 8];
    end

    // Scan from the top down so the lowest responding index is the last to assign.
    always_comb begin
        arb_data = 8'hFF;
        for (int k = NPERIPH - 1; k >= 0; k--) begin
            if (!bus.periph_oe_n[k]) begin
                arb_data = pdat[k];
            end
        end
    end

    // The edge detector resets to "active" so a strobe already low when reset
    // is released never counts as a fresh start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            active_reg <= 1'b1;
            addr_reg   <= 8'h00;
            wdata_reg  <= 8'h00;
            dout_reg   <= 8'hFF;
            chg_reg    <= 1'b0;
            wr_reg     <= 1'b0;
            regrd_reg  <= 1'b0;
            oe_n_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            active_reg <= active;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            dout_reg   <= dout_next;
            chg_reg    <= chg_next;
            wr_reg     <= wr_next;
            regrd_reg  <= regrd_next;
            oe_n_reg   <= oe_n_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        dout_next  = dout_reg;
        chg_next   = 1'b0;
        wr_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (access_wr) begin
                        state_next = HOLD;
                        if (hit_addr) begin
                            addr_next = bus.din;
                            chg_next  = 1'b1;
                        end else begin
                            wdata_next = bus.din;
                            wr_next    = 1'b1;
                        end
                    end else if (hit_addr) begin
                        state_next = RD_ADDR;
                        dout_next  = addr_reg;
                    end else begin
                        state_next = RD_DATA;
                    end
                end
            end
            RD_ADDR: begin
                if (!active) state_next = IDLE;
            end
            RD_DATA: begin
                dout_next = arb_data;
                if (!active) state_next = IDLE;
            end
            HOLD: begin
                if (!active) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        regrd_next = (state_next == RD_DATA);
        oe_n_next  = !((state_next == RD_ADDR) || (state_next == RD_DATA));
    end

    assign bus.zxuno_addr      = addr_reg;
    assign bus.zxuno_wdata     = wdata_reg;
    assign bus.dout            = dout_reg;
    assign bus.regaddr_changed = chg_reg;
    assign bus.zxuno_regwr     = wr_reg;
    assign bus.zxuno_regrd     = regrd_reg;
    assign bus.oe_n            = oe_n_reg;

`ifdef ZXUNO_REGBUS_CONFLICT_EN
    logic conflict_reg;
    logic multi_drive;

    assign multi_drive = ($countones(~bus.periph_oe_n) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_reg <= 1'b0;
        end else if (state_reg == RD_DATA && multi_drive) begin
            conflict_reg <= 1'b1;
        end
    end

    assign bus.bus_conflict = conflict_reg;
`else
    assign bus.bus_conflict = 1'b0;
`endif

endmodule
